// File: rtl/absorb_load_datapath.sv
// Packs W-bit message words into one rate-sized block, applies SHAKE pad10*1 padding and flags the final block.
// block_valid rises the cycle after the closing word (or pad cycle); block_out is held until block_ready is seen.
module absorb_load_datapath #(
  parameter int         W                 = 64,
  parameter int         RATE_MAX          = 1344,
  parameter logic [1:0] SHAKE256_MODE_VEC = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         input_size,
  input  logic [1:0]          operation_mode,
  input  logic [W-1:0]        data_in,
  input  logic                data_in_valid,
  output logic                data_in_ready,
  output logic [RATE_MAX-1:0] block_out,
  output logic                block_valid,
  input  logic                block_ready,
  output logic                last_block,
  output logic                busy
);

  localparam int LANES = W / 8;
  localparam int MAXW  = RATE_MAX / W;
  localparam int WCW   = $clog2(MAXW + 1);
  localparam int BW    = $clog2(RATE_MAX);

  typedef enum logic [1:0] {IDLE, FILL, PAD, HOLD} state_t;

  state_t              state_q, state_d;
  logic [28:0]         rem_q, rem_d;
  logic [WCW-1:0]      rate_words_q, rate_words_d;
  logic [WCW-1:0]      word_cnt_q, word_cnt_d;
  logic                suffix_q, suffix_d;
  logic [RATE_MAX-1:0] buf_q, buf_d;
  logic                ready_q, ready_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;

  logic [WCW-1:0]      wc_inc;
  logic [W-1:0]        wr_word;
  logic [BW-1:0]       wr_base;
  logic [BW-1:0]       top_bit;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    rate_words_d = rate_words_q;
    word_cnt_d   = word_cnt_q;
    suffix_d     = suffix_q;
    buf_d        = buf_q;
    wc_inc       = word_cnt_q + 1'b1;
    wr_word      = data_in;
    wr_base      = BW'(int'(word_cnt_q) * W);
    top_bit      = BW'(int'(rate_words_q) * W - 1);

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d        = input_size[31:3];
          rate_words_d = (operation_mode == SHAKE256_MODE_VEC) ? WCW'(17) : WCW'(21);
          buf_d        = '0;
          word_cnt_d   = '0;
          suffix_d     = 1'b0;
          state_d      = (input_size[31:3] != '0) ? FILL : PAD;
        end
      end
      FILL: begin
        if (data_in_valid && ready_q) begin
          if (rem_q >= 29'(LANES)) begin
            rem_d = rem_q - 29'(LANES);
          end else begin
            // Short final word: zero the unused lanes and drop the suffix right after the data
            for (int i = 0; i < LANES; i++) begin
              if (i == int'(rem_q))
                wr_word[8*i +: 8] = 8'h1F;
              else if (i > int'(rem_q))
                wr_word[8*i +: 8] = 8'h00;
            end
            rem_d    = '0;
            suffix_d = 1'b1;
          end
          buf_d[wr_base +: W] = wr_word;
          word_cnt_d          = wc_inc;
          if (wc_inc == rate_words_q)
            state_d = HOLD;
          else if (rem_d == '0 && !suffix_d)
            state_d = PAD;
          else if (suffix_d)
            state_d = HOLD;
        end
      end
      PAD: begin
        buf_d[wr_base +: 8] = 8'h1F;
        suffix_d            = 1'b1;
        state_d             = HOLD;
      end
      HOLD: begin
        if (block_ready) begin
          buf_d      = '0;
          word_cnt_d = '0;
          if (suffix_q)
            state_d = IDLE;
          else
            state_d = (rem_q == '0) ? PAD : FILL;
        end
      end
      default: state_d = IDLE;
    endcase

    // Closing pad bit lands in the last rate byte as the final block is sealed
    if (state_d == HOLD && state_q != HOLD && suffix_d)
      buf_d[top_bit] = 1'b1;

    ready_d = (state_d == FILL);
    valid_d = (state_d == HOLD);
    last_d  = (state_d == HOLD) && suffix_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      rate_words_q <= '0;
      word_cnt_q   <= '0;
      suffix_q     <= 1'b0;
      buf_q        <= '0;
      ready_q      <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      rate_words_q <= rate_words_d;
      word_cnt_q   <= word_cnt_d;
      suffix_q     <= suffix_d;
      buf_q        <= buf_d;
      ready_q      <= ready_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
    end
  end

  assign data_in_ready = ready_q;
  assign block_out     = buf_q;
  assign block_valid   = valid_q;
  assign last_block    = last_q;
  assign busy          = busy_q;

endmodule
